// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_responder
// Brief    : SPI mode-0 serial-flash read responder (READ 0x03, JEDEC ID 0x9F)
//            oversampled in the system clock domain.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
    parameter int          ADDR_W   = 16,        // 8..24
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              spi_csb,
    input  logic              spi_clk,
    input  logic              spi_io0,
    output logic              spi_io1,
    output logic              spi_io1_oe,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_cmd    = 3'd1;
    localparam logic [2:0] c_st_addr   = 3'd2;
    localparam logic [2:0] c_st_data   = 3'd3;
    localparam logic [2:0] c_st_id     = 3'd4;
    localparam logic [2:0] c_st_ignore = 3'd5;

    localparam logic [7:0] c_op_read  = 8'h03;
    localparam logic [7:0] c_op_jedec = 8'h9F;
    localparam logic [7:0] c_op_rdp   = 8'hAB;

    logic [1:0]        r_csb_s, r_clk_s, r_io0_s;
    logic              r_clk_prev;
    logic [2:0]        r_state, w_state_next;
    logic [4:0]        r_bit_cnt;
    logic [ADDR_W-2:0] r_shift;
    logic [7:0]        r_tx;
    logic              r_io1, r_oe, r_mem_rd, r_rd_d, r_cmd_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [1:0]        r_id_idx, w_id_next;
    logic [7:0]        w_id_byte;

    logic              w_csb, w_io0, w_rise, w_fall;
    logic [7:0]        w_op;
    logic [ADDR_W-1:0] w_addr;

    assign w_csb  = r_csb_s[1];
    assign w_io0  = r_io0_s[1];
    assign w_rise = r_clk_s[1] & ~r_clk_prev;
    assign w_fall = ~r_clk_s[1] & r_clk_prev;
    assign w_op   = {r_shift[6:0], w_io0};
    assign w_addr = {r_shift, w_io0};

    assign w_id_next = (r_id_idx == 2'd2) ? 2'd0 : r_id_idx + 2'd1;
    always_comb begin
        w_id_byte = JEDEC_ID[23:16];
        case (w_id_next)
            2'd1:    w_id_byte = JEDEC_ID[15:8];
            2'd2:    w_id_byte = JEDEC_ID[7:0];
            default: w_id_byte = JEDEC_ID[23:16];
        endcase
    end

    // csb synchronizer resets high so busy reads 0 straight out of reset
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_csb_s    <= 2'b11;
            r_clk_s    <= 2'b00;
            r_io0_s    <= 2'b00;
            r_clk_prev <= 1'b0;
        end else begin
            r_csb_s    <= {r_csb_s[0], spi_csb};
            r_clk_s    <= {r_clk_s[0], spi_clk};
            r_io0_s    <= {r_io0_s[0], spi_io0};
            r_clk_prev <= r_clk_s[1];
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) r_state <= c_st_idle;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_csb) begin
            w_state_next = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: w_state_next = c_st_cmd;
                c_st_cmd:
                    if (w_rise && r_bit_cnt == 5'd7) begin
                        if (w_op == c_op_read)       w_state_next = c_st_addr;
                        else if (w_op == c_op_jedec) w_state_next = c_st_id;
                        else                         w_state_next = c_st_ignore;
                    end
                c_st_addr:
                    if (w_rise && r_bit_cnt == 5'd23) w_state_next = c_st_data;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_bit_cnt  <= 5'd0;
            r_shift    <= '0;
            r_tx       <= 8'd0;
            r_io1      <= 1'b0;
            r_oe       <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_rd_d     <= 1'b0;
            r_mem_addr <= '0;
            r_id_idx   <= 2'd0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_mem_rd  <= 1'b0;
            r_cmd_err <= 1'b0;
            r_rd_d    <= r_mem_rd;
            if (w_csb) begin
                r_oe      <= 1'b0;
                r_bit_cnt <= 5'd0;
                r_io1     <= 1'b0;
                r_rd_d    <= 1'b0;
            end else begin
                case (r_state)
                    c_st_cmd:
                        if (w_rise) begin
                            r_shift   <= {r_shift[ADDR_W-3:0], w_io0};
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt <= 5'd0;
                                if (w_op == c_op_jedec) begin
                                    r_tx     <= JEDEC_ID[23:16];
                                    r_oe     <= 1'b1;
                                    r_id_idx <= 2'd0;
                                end else if (w_op != c_op_read && w_op != c_op_rdp) begin
                                    r_cmd_err <= 1'b1;
                                end
                            end
                        end
                    c_st_addr:
                        if (w_rise) begin
                            r_shift   <= {r_shift[ADDR_W-3:0], w_io0};
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd23) begin
                                r_bit_cnt  <= 5'd0;
                                r_mem_rd   <= 1'b1;
                                r_mem_addr <= w_addr;
                            end
                        end
                    c_st_data, c_st_id: begin
                        if (w_fall) begin
                            r_io1 <= r_tx[7];
                            r_tx  <= {r_tx[6:0], 1'b0};
                        end
                        if (w_rise) begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt <= 5'd0;
                                if (r_state == c_st_data) begin
                                    r_mem_rd   <= 1'b1;
                                    r_mem_addr <= r_mem_addr + 1'b1;
                                end else begin
                                    r_id_idx <= w_id_next;
                                    r_tx     <= w_id_byte;
                                end
                            end
                        end
                    end
                    default: r_bit_cnt <= 5'd0;
                endcase
                // memory data arrives one clock after the strobe
                if (r_rd_d) begin
                    r_tx <= mem_rdata;
                    r_oe <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        spi_io1    = r_io1 & r_oe;
        spi_io1_oe = r_oe;
        mem_rd     = r_mem_rd;
        mem_addr   = r_mem_addr;
        busy       = ~w_csb;
        cmd_err    = r_cmd_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_responder
// Brief    : Self-checking bench with a byte-wide memory model and scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_responder;
    localparam int ADDR_W = 16;
    localparam int HALF   = 8;   // system clocks per SPI half period

    logic              clock = 1'b0;
    logic              resetb, spi_csb, spi_clk, spi_io0;
    logic              spi_io1, spi_io1_oe, mem_rd, busy, cmd_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;

    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic [7:0]        exp_data_q [$];
    logic [ADDR_W-1:0] exp_addr_q [$];
    int                n_checks = 0;
    int                n_fail   = 0;
    int                err_cnt  = 0;

    always #5 clock = ~clock;

    spi_flash_responder #(.ADDR_W(ADDR_W), .JEDEC_ID(24'hEF4016)) dut (
        .clock(clock), .resetb(resetb), .spi_csb(spi_csb), .spi_clk(spi_clk),
        .spi_io0(spi_io0), .spi_io1(spi_io1), .spi_io1_oe(spi_io1_oe),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .busy(busy), .cmd_err(cmd_err)
    );

    always @(posedge clock) if (mem_rd) mem_rdata <= mem[mem_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (resetb && mem_rd) begin
            if (exp_addr_q.size() == 0) check("mem_rd_unexpected", 64'(mem_rd), 64'd0);
            else check("mem_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
        end
        if (resetb && cmd_err) err_cnt++;
    end

    task automatic spi_bit(input logic mosi, output logic miso);
        spi_io0 = mosi;
        repeat (HALF) @(negedge clock);
        miso = spi_io1;
        spi_clk = 1'b1;
        repeat (HALF) @(negedge clock);
        spi_clk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rx[i] = b;
        end
    endtask

    task automatic cs_low();
        @(negedge clock);
        spi_csb = 1'b0;
        repeat (HALF) @(negedge clock);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clock);
        spi_csb = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic send_read_hdr(input logic [23:0] a);
        logic [7:0] rx;
        spi_byte(8'h03, rx);
        spi_byte(a[23:16], rx);
        spi_byte(a[15:8], rx);
        spi_byte(a[7:0], rx);
    endtask

    task automatic read_xact(input logic [23:0] a, input int nbytes);
        logic [7:0]        rx;
        logic [ADDR_W-1:0] base;
        base = a[ADDR_W-1:0];
        for (int k = 0; k <= nbytes; k++) exp_addr_q.push_back(base + ADDR_W'(k));
        cs_low();
        send_read_hdr(a);
        for (int k = 0; k < nbytes; k++) begin
            exp_data_q.push_back(mem[base + ADDR_W'(k)]);
            spi_byte(8'h00, rx);
            check("read_data", 64'(rx), 64'(exp_data_q.pop_front()));
        end
        check("read_oe_active", 64'(spi_io1_oe), 64'd1);
        cs_high();
        check("read_rd_left", 64'(exp_addr_q.size()), 64'd0);
        check("read_oe_after", 64'(spi_io1_oe), 64'd0);
    endtask

    task automatic jedec_xact(input int nbytes);
        logic [7:0]  rx;
        logic [23:0] id;
        id = 24'hEF4016;
        cs_low();
        spi_byte(8'h9F, rx);
        for (int k = 0; k < nbytes; k++) begin
            case (k % 3)
                0:       exp_data_q.push_back(id[23:16]);
                1:       exp_data_q.push_back(id[15:8]);
                default: exp_data_q.push_back(id[7:0]);
            endcase
            spi_byte(8'h00, rx);
            check("jedec_data", 64'(rx), 64'(exp_data_q.pop_front()));
        end
        cs_high();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        logic       b;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[16'h0010] = 8'hAB; mem[16'h0011] = 8'hCD;
        mem[16'h0012] = 8'hEF; mem[16'h0013] = 8'h12;
        mem[16'hFFFF] = 8'h5C; mem[16'h0000] = 8'hA7; mem[16'h0001] = 8'h3E;

        resetb = 1'b0; spi_csb = 1'b1; spi_clk = 1'b0; spi_io0 = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_io1", 64'(spi_io1), 64'd0);
        check("rst_oe", 64'(spi_io1_oe), 64'd0);
        check("rst_mem_rd", 64'(mem_rd), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cmd_err", 64'(cmd_err), 64'd0);
        resetb = 1'b1;
        repeat (4) @(negedge clock);

        // READ with prefetch
        read_xact(24'h000010, 3);

        // JEDEC ID wraps after three bytes
        jedec_xact(6);

        // unsupported opcode
        err_cnt = 0;
        cs_low();
        check("busy_active", 64'(busy), 64'd1);
        spi_byte(8'h5A, rx);
        for (int k = 0; k < 2; k++) begin
            exp_data_q.push_back(8'h00);
            spi_byte(8'hFF, rx);
            check("bad_miso", 64'(rx), 64'(exp_data_q.pop_front()));
        end
        check("bad_oe", 64'(spi_io1_oe), 64'd0);
        cs_high();
        check("bad_cmd_err_cnt", 64'(err_cnt), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);

        // 0xAB is silently ignored
        err_cnt = 0;
        cs_low();
        spi_byte(8'hAB, rx);
        spi_byte(8'h00, rx);
        check("rdp_oe", 64'(spi_io1_oe), 64'd0);
        cs_high();
        check("rdp_cmd_err_cnt", 64'(err_cnt), 64'd0);

        // address wrap
        read_xact(24'h00FFFF, 2);

        // abort after 12 address bits
        cs_low();
        spi_byte(8'h03, rx);
        for (int i = 0; i < 12; i++) spi_bit(1'b0, b);
        cs_high();
        check("abort_oe", 64'(spi_io1_oe), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        jedec_xact(3);

        // async reset mid-DATA
        exp_addr_q.push_back(16'h0010);
        exp_addr_q.push_back(16'h0011);
        cs_low();
        send_read_hdr(24'h000010);
        exp_data_q.push_back(mem[16'h0010]);
        spi_byte(8'h00, rx);
        check("prerst_data", 64'(rx), 64'(exp_data_q.pop_front()));
        for (int i = 0; i < 4; i++) spi_bit(1'b0, b);
        check("prerst_oe", 64'(spi_io1_oe), 64'd1);
        check("prerst_busy", 64'(busy), 64'd1);
        @(negedge clock);
        #2 resetb = 1'b0;
        #1;
        check("arst_io1", 64'(spi_io1), 64'd0);
        check("arst_oe", 64'(spi_io1_oe), 64'd0);
        check("arst_mem_rd", 64'(mem_rd), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        spi_csb = 1'b1; spi_clk = 1'b0;
        repeat (4) @(negedge clock);
        resetb = 1'b1;
        repeat (4) @(negedge clock);
        check("arst_rd_left", 64'(exp_addr_q.size()), 64'd0);
        read_xact(24'h000012, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
